// File: rtl/instr_issue_ctrl.sv
// Host-side instruction sequencer: buffers a program loaded while idle, then issues it
// one word per cycle to the array, stalling on EX (finish flag) and WBPSRAM (writeback beats).
`timescale 1ns/1ps
module instr_issue_ctrl #(
  parameter int BIT_INSTR  = 24,
  parameter int BIT_OPCODE = 4,
  parameter int DEPTH      = 128,
  parameter int BIT_PC     = 7,
  parameter int WB_BEATS   = 16,
  parameter int TIMEOUT    = 4096,
  // Opcode values mirror `OPCODE_EX / `OPCODE_WBPSRAM of the array's param.v
  parameter logic [BIT_OPCODE-1:0] OPCODE_EX      = BIT_OPCODE'(2),
  parameter logic [BIT_OPCODE-1:0] OPCODE_WBPSRAM = BIT_OPCODE'(3)
) (
  input  logic                 CLK,
  input  logic                 RSTb,
  input  logic                 i_Load_En,
  input  logic [BIT_PC-1:0]    i_Load_Addr,
  input  logic [BIT_INSTR-1:0] i_Load_Instr,
  input  logic                 i_Start,
  input  logic [BIT_PC:0]      i_Num_Instr,
  input  logic                 i_Flag_Finish,
  input  logic                 i_Valid_WB,
  output logic [BIT_INSTR-1:0] o_Instr,
  output logic                 o_Busy,
  output logic                 o_Done,
  output logic                 o_Err,
  output logic [BIT_PC-1:0]    o_PC
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BW = $clog2(WB_BEATS + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_EX, S_WAIT_WB, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic [BIT_INSTR-1:0]   mem [DEPTH];
  logic [BIT_PC:0]        pc, pc_inc, len;
  logic [TW-1:0]          tcnt;
  logic [BW-1:0]          beat;
  logic [BIT_INSTR-1:0]   cur_word;
  logic [BIT_OPCODE-1:0]  cur_op;
  logic                   cur_valid, is_ex, is_wb, more, tmo, wait_exit;

  always_ff @(posedge CLK) begin
    if (i_Load_En && state == S_IDLE)
      mem[i_Load_Addr] <= i_Load_Instr;
  end

  always_comb begin
    cur_word  = mem[pc[BIT_PC-1:0]];
    cur_valid = cur_word[BIT_INSTR-1];
    cur_op    = cur_word[BIT_INSTR-2 -: BIT_OPCODE];
    is_ex     = cur_valid && (cur_op == OPCODE_EX);
    is_wb     = cur_valid && (cur_op == OPCODE_WBPSRAM);
    pc_inc    = pc + (BIT_PC+1)'(1);
    more      = (pc < len);
    tmo       = (tcnt == TW'(TIMEOUT - 1));
    // The beat that completes the count exits in the same cycle it is seen
    wait_exit = ((state == S_WAIT_EX) && i_Flag_Finish) ||
                ((state == S_WAIT_WB) && i_Valid_WB && (beat == BW'(WB_BEATS - 1)));
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (i_Start) state_nxt = (i_Num_Instr == '0) ? S_DONE : S_ISSUE;
      S_ISSUE:
        if (is_ex)                state_nxt = S_WAIT_EX;
        else if (is_wb)           state_nxt = S_WAIT_WB;
        else if (pc_inc >= len)   state_nxt = S_DONE;
      S_WAIT_EX, S_WAIT_WB:
        if (wait_exit)            state_nxt = more ? S_ISSUE : S_DONE;
        else if (tmo)             state_nxt = S_DONE;
      S_DONE:                     state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_Busy = 1'b0;
    o_Done = 1'b0;
    unique case (state)
      S_ISSUE, S_WAIT_EX, S_WAIT_WB: o_Busy = 1'b1;
      S_DONE:                        o_Done = 1'b1;
      default: ;
    endcase
  end

  // o_Instr defaults to zero so every word is presented for exactly one cycle
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      o_Instr <= '0;
      o_PC    <= '0;
      o_Err   <= 1'b0;
      pc      <= '0;
      len     <= '0;
      tcnt    <= '0;
      beat    <= '0;
    end else begin
      o_Instr <= '0;
      unique case (state)
        S_IDLE:
          if (i_Start) begin
            len   <= i_Num_Instr;
            pc    <= '0;
            o_Err <= 1'b0;
          end
        S_ISSUE: begin
          o_Instr <= cur_valid ? cur_word : '0;
          o_PC    <= pc[BIT_PC-1:0];
          pc      <= pc_inc;
          tcnt    <= '0;
          beat    <= '0;
        end
        S_WAIT_EX, S_WAIT_WB: begin
          tcnt <= tcnt + TW'(1);
          if (state == S_WAIT_WB && i_Valid_WB) beat <= beat + BW'(1);
          if (!wait_exit && tmo) o_Err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Bench for instr_issue_ctrl: a program-level trace generator predicts every output cycle
// and the input schedule (flags, beats, ignored noise) that produces it.
`timescale 1ns/1ps
module tb_instr_issue_ctrl;

  localparam int BIT_INSTR = 24, BIT_OPCODE = 4, DEPTH = 128, BIT_PC = 7;
  localparam int WB_BEATS = 16, TIMEOUT = 64;
  localparam logic [3:0] OP_LD = 4'd1, OP_EX = 4'd2, OP_WB = 4'd3;

  logic        CLK = 1'b0, RSTb = 1'b0;
  logic        i_Load_En, i_Start, i_Flag_Finish, i_Valid_WB;
  logic [6:0]  i_Load_Addr;
  logic [23:0] i_Load_Instr;
  logic [7:0]  i_Num_Instr;
  logic [23:0] o_Instr;
  logic        o_Busy, o_Done, o_Err;
  logic [6:0]  o_PC;

  always #5 CLK = ~CLK;

  instr_issue_ctrl #(
    .BIT_INSTR(BIT_INSTR), .BIT_OPCODE(BIT_OPCODE), .DEPTH(DEPTH), .BIT_PC(BIT_PC),
    .WB_BEATS(WB_BEATS), .TIMEOUT(TIMEOUT), .OPCODE_EX(OP_EX), .OPCODE_WBPSRAM(OP_WB)
  ) dut (
    .CLK(CLK), .RSTb(RSTb), .i_Load_En(i_Load_En), .i_Load_Addr(i_Load_Addr),
    .i_Load_Instr(i_Load_Instr), .i_Start(i_Start), .i_Num_Instr(i_Num_Instr),
    .i_Flag_Finish(i_Flag_Finish), .i_Valid_WB(i_Valid_WB), .o_Instr(o_Instr),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Err(o_Err), .o_PC(o_PC)
  );

  typedef struct {
    logic [23:0] instr;
    logic [6:0]  pc;
    bit          pc_chk;
    bit          busy;
    bit          done;
    bit          err;
  } exp_t;

  exp_t        exp_q[$];
  bit          fl_q[$];
  bit          wb_q[$];
  logic [23:0] mem_m [DEPTH];
  bit          err_m;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    assert (act === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, expv);
    end
  endtask

  function automatic logic [23:0] mk_word(input bit v, input logic [3:0] op);
    logic [18:0] pay;
    pay = 19'($urandom);
    return {v, op, pay};
  endfunction

  function automatic logic [23:0] rnd_word();
    int r;
    r = $urandom_range(0, 15);
    if (r < 2)      return mk_word(1'b0, 4'($urandom_range(4, 15)));
    else if (r == 2) return mk_word(1'b1, OP_EX);
    else if (r == 3) return mk_word(1'b1, OP_WB);
    else if (r < 6)  return mk_word(1'b1, 4'($urandom_range(4, 15)));
    else             return mk_word(1'b1, OP_LD);
  endfunction

  function automatic void push_exp(input logic [23:0] ins, input int pc, input bit pcc,
                                   input bit busy, input bit done);
    exp_t e;
    e.instr = ins; e.pc = 7'(pc); e.pc_chk = pcc; e.busy = busy; e.done = done; e.err = err_m;
    exp_q.push_back(e);
  endfunction

  function automatic void push_in(input bit f, input bit w);
    fl_q.push_back(f);
    wb_q.push_back(w);
  endfunction

  // Entry t = outputs seen after clock edge t (edge 0 accepts the start); inputs for the
  // cycle ending at edge t. ex_f: >0 forces the wait cycle the flag rises, -1 never, 0 random.
  task automatic gen(input int n, input int ex_f, input bit allow_tmo);
    int last_pc;
    bit finished;
    exp_q.delete(); fl_q.delete(); wb_q.delete();
    err_m = 1'b0;
    if (n == 0) begin
      push_in(0, 0); push_exp('0, 0, 0, 0, 1);
      push_in(1'($urandom), 1'($urandom)); push_exp('0, 0, 0, 0, 0);
      return;
    end
    push_in(0, 0); push_exp('0, 0, 0, 1, 0);
    finished = 0;
    last_pc = 0;
    for (int idx = 0; idx < n && !finished; idx++) begin
      logic [23:0] w;
      bit v, is_ex, is_wb;
      w = mem_m[idx];
      v = w[23];
      is_ex = v && (w[22:19] == OP_EX);
      is_wb = v && (w[22:19] == OP_WB);
      last_pc = idx;
      push_in(1'($urandom), 1'($urandom));
      if (!(is_ex || is_wb) && idx == n - 1) begin
        push_exp(v ? w : '0, idx, 1, 0, 1);
        finished = 1;
      end else begin
        push_exp(v ? w : '0, idx, 1, 1, 0);
      end
      if (is_ex || is_wb) begin
        int f_at, cnt;
        bit tmo_mode;
        f_at = 0; cnt = 0; tmo_mode = 0;
        if (is_ex) begin
          if (ex_f > 0)       f_at = ex_f;
          else if (ex_f < 0)  f_at = 0;
          else if (allow_tmo && $urandom_range(0, 9) == 0) f_at = 0;
          else                f_at = $urandom_range(1, 12);
        end else begin
          tmo_mode = allow_tmo && ($urandom_range(0, 9) == 0);
        end
        for (int j = 1; j <= TIMEOUT; j++) begin
          bit fl, wbp, ex_now;
          if (is_ex) begin
            fl = (f_at != 0) && (j >= f_at);
            wbp = 1'($urandom);
            ex_now = fl;
          end else begin
            fl = 1'($urandom);
            if (tmo_mode) wbp = (cnt < WB_BEATS - 1) && ($urandom_range(0, 3) == 0);
            else          wbp = 1'($urandom);
            if (wbp) cnt++;
            ex_now = (cnt == WB_BEATS);
          end
          push_in(fl, wbp);
          if (ex_now) begin
            if (idx < n - 1) push_exp('0, idx, 1, 1, 0);
            else begin push_exp('0, idx, 1, 0, 1); finished = 1; end
            break;
          end else if (j == TIMEOUT) begin
            err_m = 1'b1;
            push_exp('0, idx, 1, 0, 1);
            finished = 1;
          end else begin
            push_exp('0, idx, 1, 1, 0);
          end
        end
      end
    end
    push_in(1'($urandom), 1'($urandom));
    push_exp('0, last_pc, 1, 0, 0);
  endtask

  task automatic idle_inputs();
    i_Load_En = 0; i_Load_Addr = '0; i_Load_Instr = '0; i_Start = 0;
    i_Num_Instr = '0; i_Flag_Finish = 0; i_Valid_WB = 0;
  endtask

  task automatic load(input int addr, input logic [23:0] w);
    @(negedge CLK);
    i_Load_En = 1; i_Load_Addr = 7'(addr); i_Load_Instr = w;
    mem_m[addr] = w;
    @(posedge CLK); #1;
    i_Load_En = 0;
  endtask

  task automatic run(input string name, input int n, input int ex_f, input bit allow_tmo,
                     input bit load_same);
    logic [23:0] lw;
    lw = '0;
    if (load_same) begin lw = rnd_word(); mem_m[0] = lw; end
    gen(n, ex_f, allow_tmo);
    @(negedge CLK);
    i_Start = 1; i_Num_Instr = 8'(n);
    i_Load_En = load_same; i_Load_Addr = '0; i_Load_Instr = lw;
    i_Flag_Finish = fl_q[0]; i_Valid_WB = wb_q[0];
    for (int t = 0; t < exp_q.size(); t++) begin
      @(negedge CLK);
      chk($sformatf("%s.t%0d.instr", name, t), 32'(o_Instr), 32'(exp_q[t].instr));
      chk($sformatf("%s.t%0d.busy",  name, t), 32'(o_Busy),  32'(exp_q[t].busy));
      chk($sformatf("%s.t%0d.done",  name, t), 32'(o_Done),  32'(exp_q[t].done));
      chk($sformatf("%s.t%0d.err",   name, t), 32'(o_Err),   32'(exp_q[t].err));
      if (exp_q[t].pc_chk)
        chk($sformatf("%s.t%0d.pc", name, t), 32'(o_PC), 32'(exp_q[t].pc));
      if (t + 1 < exp_q.size()) begin
        i_Flag_Finish = fl_q[t+1];
        i_Valid_WB    = wb_q[t+1];
        i_Start       = ($urandom_range(0, 7) == 0);
        i_Num_Instr   = 8'($urandom);
        i_Load_En     = ($urandom_range(0, 7) == 0);
        i_Load_Addr   = 7'($urandom);
        i_Load_Instr  = 24'($urandom);
      end else begin
        idle_inputs();
      end
    end
  endtask

  initial begin
    idle_inputs();
    RSTb = 0;
    #12;
    chk("reset.instr", 32'(o_Instr), 32'd0);
    chk("reset.busy",  32'(o_Busy),  32'd0);
    chk("reset.done",  32'(o_Done),  32'd0);
    chk("reset.err",   32'(o_Err),   32'd0);
    chk("reset.pc",    32'(o_PC),    32'd0);
    @(negedge CLK);
    RSTb = 1;

    // 120 LDSRAMs, EX (flag after 37 quiet wait cycles), WBPSRAM last
    for (int i = 0; i < DEPTH; i++) begin
      if (i < 120)       load(i, mk_word(1'b1, OP_LD));
      else if (i == 120) load(i, mk_word(1'b1, OP_EX));
      else if (i == 121) load(i, mk_word(1'b1, OP_WB));
      else               load(i, rnd_word());
    end
    run("progA", 122, 38, 1'b0, 1'b0);

    load(3, mk_word(1'b0, OP_LD));
    run("bubble", 8, 0, 1'b0, 1'b0);

    load(3, mk_word(1'b1, OP_EX));
    run("ex_timeout", 4, -1, 1'b0, 1'b0);
    run("zero_len", 0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < DEPTH; i++) load(i, rnd_word());
      run($sformatf("rand%0d", k), (k == 0) ? DEPTH : $urandom_range(1, DEPTH), 0, 1'b1,
          (k % 2) == 1);
    end

    // Asynchronous reset while issuing index 50
    for (int i = 0; i < DEPTH; i++) load(i, mk_word(1'b1, OP_LD));
    @(negedge CLK);
    i_Start = 1; i_Num_Instr = 8'd100;
    @(negedge CLK);
    i_Start = 0;
    repeat (51) @(posedge CLK);
    #1;
    chk("mid.pc_before",    32'(o_PC),    32'd50);
    chk("mid.instr_before", 32'(o_Instr), 32'(mem_m[50]));
    #1 RSTb = 0;
    #1;
    chk("mid.instr", 32'(o_Instr), 32'd0);
    chk("mid.busy",  32'(o_Busy),  32'd0);
    chk("mid.pc",    32'(o_PC),    32'd0);
    chk("mid.done",  32'(o_Done),  32'd0);
    @(negedge CLK);
    RSTb = 1;
    run("restart", 60, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
